// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC, line fetch FSM, line buffer and decode queue.
// Define FETCH_LINE_BUFFER_EN to keep the line buffer across pushes and redirects.
module fetch_queue_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     LINE_BITS   = 128,
  parameter int unsigned     QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_pc_plus4,
  output logic                 mem_req,
  output logic [XLEN-1:0]      mem_addr,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_rvalid
);

  localparam int unsigned     WORDS      = LINE_BITS / 32;
  localparam int unsigned     LINE_BYTES = LINE_BITS / 8;
  localparam int unsigned     PTR_W      = $clog2(QUEUE_DEPTH);
  localparam int unsigned     CNT_W      = PTR_W + 1;
  localparam logic [XLEN-1:0] LINE_MASK  = ~XLEN'(LINE_BYTES - 1);
  localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
`ifdef FETCH_LINE_BUFFER_EN
  localparam bit LB_KEEP = 1'b1;
`else
  localparam bit LB_KEEP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD
  } state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]        mem_addr_q, mem_addr_d;
  logic                   lb_valid_q, lb_valid_d;
  logic [XLEN-1:0]        lb_tag_q, lb_tag_d;
  logic [LINE_BITS-1:0]   lb_data_q, lb_data_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [31:0]            q_instr_q [QUEUE_DEPTH];
  logic [XLEN-1:0]        q_pc_q    [QUEUE_DEPTH];
  logic [XLEN-1:0]        q_pc4_q   [QUEUE_DEPTH];

  logic [XLEN-1:0]        fetch_line;
  logic [XLEN-1:0]        redir_pc;
  logic [XLEN-1:0]        redir_line;
  logic [XLEN-1:0]        word_sel;
  logic [31:0]            push_word;
  logic                   hit;
  logic                   push;
  logic                   pop;
  logic                   rsp_done;

  assign fetch_line = fetch_pc_q & LINE_MASK;
  assign redir_pc   = redirect_pc & WORD_MASK;
  assign redir_line = redir_pc & LINE_MASK;
  assign word_sel   = (fetch_pc_q >> 2) & XLEN'(WORDS - 1);
  assign hit        = lb_valid_q && (lb_tag_q == fetch_line);
  assign push       = !redirect_valid && hit && (count_q < CNT_W'(QUEUE_DEPTH));
  assign pop        = out_valid && out_ready;
  assign rsp_done   = mem_rvalid && (state_q != ST_IDLE);

  always_comb begin
    push_word = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (word_sel == XLEN'(k)) push_word = lb_data_q[32*k +: 32];
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    lb_valid_d = lb_valid_q;
    lb_tag_d   = lb_tag_q;
    lb_data_d  = lb_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      if (!LB_KEEP) lb_valid_d = 1'b0;
      // A response arriving with the redirect is dropped, so the target line
      // can be requested immediately rather than after a pass through IDLE.
      if (state_q == ST_IDLE || rsp_done) begin
        if (!(lb_valid_d && (lb_tag_q == redir_line))) begin
          state_d    = ST_WAIT;
          mem_addr_d = redir_line;
        end else begin
          state_d    = ST_IDLE;
        end
      end else begin
        state_d = ST_DISCARD;
      end
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        tail_d     = tail_q + PTR_W'(1);
        if (!LB_KEEP) lb_valid_d = 1'b0;
      end
      head_d  = head_q + PTR_W'(pop);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      unique case (state_q)
        ST_IDLE: begin
          if (!hit) begin
            state_d    = ST_WAIT;
            mem_addr_d = fetch_line;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            lb_valid_d = 1'b1;
            lb_tag_d   = mem_addr_q;
            lb_data_d  = mem_rdata;
            state_d    = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (mem_rvalid) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= '0;
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      lb_valid_q <= lb_valid_d;
      lb_tag_q   <= lb_tag_d;
      lb_data_q  <= lb_data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
        q_pc4_q[i]   <= '0;
      end
    end else if (push) begin
      q_instr_q[tail_q] <= push_word;
      q_pc_q[tail_q]    <= fetch_pc_q;
      q_pc4_q[tail_q]   <= fetch_pc_q + XLEN'(4);
    end
  end

  assign out_valid    = (count_q != '0);
  assign out_instr    = q_instr_q[head_q];
  assign out_pc       = q_pc_q[head_q];
  assign out_pc_plus4 = q_pc4_q[head_q];
  assign mem_req      = (state_q == ST_WAIT);
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: per-cycle vector table plus multi-cycle sequences
// driven by a two-cycle-latency memory responder. Honours FETCH_LINE_BUFFER_EN.
module tb_fetch_queue_unit;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_instr;
  logic [31:0]  out_pc;
  logic [31:0]  out_pc_plus4;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic         mem_rvalid = 1'b0;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .XLEN       (32),
    .LINE_BITS  (128),
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid)
  );

  int nvec = 0;
  int nerr = 0;

  bit          mem_auto = 1'b0;
  bit          pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] paddr = '0;
  int          nreq = 0;
  int          nreq0 = 0;

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hA5A5_0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic [127:0] line(input logic [31:0] a);
    return {w(a + 32'd12), w(a + 32'd8), w(a + 32'd4), w(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled at the negedge, where the
  // memory model decides this cycle's response.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (mem_auto) begin
      if (pend) begin
        if (pcnt <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = line(paddr);
          pend       = 1'b0;
        end else begin
          pcnt--;
        end
      end else if (mem_req) begin
        pend  = 1'b1;
        pcnt  = 2;
        paddr = mem_addr;
        nreq++;
        if (mem_addr == 32'h0) nreq0++;
      end
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    mem_auto       = 1'b0;
    pend           = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    nreq           = 0;
    nreq0          = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int maxc, input string nm);
    int c = 0;
    while (!out_valid && c < maxc) begin
      step();
      c++;
    end
    chk(nm, {31'h0, out_valid}, 32'h1);
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        mv;
    logic [31:0] ml;
    logic        ev;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t V(input logic redir, input logic [31:0] rpc, input logic mv,
                             input logic [31:0] ml, input logic ev, input logic [31:0] epc,
                             input logic ereq, input logic [31:0] eaddr);
    vec_t r;
    r.redir = redir; r.rpc = rpc; r.mv = mv; r.ml = ml;
    r.ev = ev; r.epc = epc; r.ereq = ereq; r.eaddr = eaddr;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   got;
    bit   saw10;

`ifndef FETCH_LINE_BUFFER_EN
    // One request per instruction; memory answers two cycles after mem_req rises.
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     0, 32'h0));   // 0 reset state
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h0));   // 1
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h0));   // 2
    tbl.push_back(V(0, 0,     1, 32'h0, 0, 0,     1, 32'h0));   // 3 response A0..A3
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     0, 0));       // 4 push pc 0
    tbl.push_back(V(0, 0,     0, 0,     1, 32'h0, 0, 0));       // 5
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h0));   // 6
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h0));   // 7
    tbl.push_back(V(0, 0,     1, 32'h0, 0, 0,     1, 32'h0));   // 8
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     0, 0));       // 9
    tbl.push_back(V(0, 0,     0, 0,     1, 32'h4, 0, 0));       // 10
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h0));   // 11
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h0));   // 12
    tbl.push_back(V(0, 0,     1, 32'h0, 0, 0,     1, 32'h0));   // 13
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     0, 0));       // 14
    tbl.push_back(V(0, 0,     0, 0,     1, 32'h8, 0, 0));       // 15
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h0));   // 16
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h0));   // 17
    tbl.push_back(V(0, 0,     1, 32'h0, 0, 0,     1, 32'h0));   // 18
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     0, 0));       // 19
    tbl.push_back(V(0, 0,     0, 0,     1, 32'hC, 0, 0));       // 20
    tbl.push_back(V(1, 32'h46, 0, 0,    0, 0,     1, 32'h10));  // 21 redirect in WAIT
    tbl.push_back(V(0, 0,     1, 32'h10, 0, 0,    0, 0));       // 22 stale response
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     0, 0));       // 23
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h40));  // 24
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h40));  // 25
    tbl.push_back(V(0, 0,     1, 32'h40, 0, 0,    1, 32'h40));  // 26
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     0, 0));       // 27
    tbl.push_back(V(0, 0,     0, 0,     1, 32'h44, 0, 0));      // 28
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h40));  // 29
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h40));  // 30
    tbl.push_back(V(1, 32'h80, 1, 32'h40, 0, 0,   1, 32'h40));  // 31 redirect with rvalid
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h80));  // 32
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     1, 32'h80));  // 33
    tbl.push_back(V(0, 0,     1, 32'h80, 0, 0,    1, 32'h80));  // 34
    tbl.push_back(V(0, 0,     0, 0,     0, 0,     0, 0));       // 35
    tbl.push_back(V(0, 0,     0, 0,     1, 32'h80, 0, 0));      // 36

    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("t%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("t%0d_req", i), {31'h0, mem_req}, {31'h0, tbl[i].ereq});
      if (tbl[i].ereq || i == 0) chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].eaddr);
      if (i == 0) begin
        chk("t0_pc", out_pc, 32'h0);
        chk("t0_instr", out_instr, 32'h0);
        chk("t0_pc4", out_pc_plus4, 32'h0);
      end
      if (tbl[i].ev) begin
        chk($sformatf("t%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("t%0d_instr", i), out_instr, w(tbl[i].epc));
        chk($sformatf("t%0d_pc4", i), out_pc_plus4, tbl[i].epc + 32'd4);
      end
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      mem_rvalid     = tbl[i].mv;
      mem_rdata      = tbl[i].mv ? line(tbl[i].ml) : '0;
      step();
    end
    redirect_valid = 1'b0;
`endif

    // Streaming line 0 with decode always ready; count requests before 0x10.
    do_reset();
    out_ready = 1'b1;
    mem_auto  = 1'b1;
    got   = 0;
    saw10 = 1'b0;
    for (int c = 0; c < 80 && !(got >= 4 && saw10); c++) begin
      if (out_valid && got < 4) begin
        chk($sformatf("s1_pc%0d", got), out_pc, 32'(got * 4));
        chk($sformatf("s1_instr%0d", got), out_instr, w(32'(got * 4)));
        got++;
      end
      if (mem_req && mem_addr == 32'h10) saw10 = 1'b1;
      step();
    end
    chk("s1_outputs", 32'(got), 32'd4);
    chk("s1_req_0x10", {31'h0, saw10}, 32'h1);
`ifdef FETCH_LINE_BUFFER_EN
    chk("s1_req_line0", 32'(nreq0), 32'd1);
`else
    chk("s1_req_line0", 32'(nreq0), 32'd4);
`endif

    // Decode stalled: queue fills to depth, head held, then drains in order.
    do_reset();
    mem_auto = 1'b1;
    wait_valid(40, "s2_first_valid");
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("s2_hold_valid%0d", c), {31'h0, out_valid}, 32'h1);
      chk($sformatf("s2_hold_pc%0d", c), out_pc, 32'h0);
      step();
    end
    chk("s2_idle_req", {31'h0, mem_req}, 32'h0);
`ifdef FETCH_LINE_BUFFER_EN
    chk("s2_req_count", 32'(nreq), 32'd2);
`else
    chk("s2_req_count", 32'(nreq), 32'd5);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("s2_drain_valid%0d", k), {31'h0, out_valid}, 32'h1);
      chk($sformatf("s2_drain_pc%0d", k), out_pc, 32'(k * 4));
      chk($sformatf("s2_drain_instr%0d", k), out_instr, w(32'(k * 4)));
      step();
    end

    // Redirect while full and popping; target 0x14 sits in the last fetched line 0x10.
    do_reset();
    mem_auto = 1'b1;
    repeat (40) step();
    chk("s3_full_valid", {31'h0, out_valid}, 32'h1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h17;
    step();
    redirect_valid = 1'b0;
    chk("s3_empty_after_redirect", {31'h0, out_valid}, 32'h0);
`ifdef FETCH_LINE_BUFFER_EN
    chk("s3_no_req", {31'h0, mem_req}, 32'h0);
    step();
    chk("s3_valid_next", {31'h0, out_valid}, 32'h1);
    chk("s3_no_req2", {31'h0, mem_req}, 32'h0);
`else
    chk("s3_req", {31'h0, mem_req}, 32'h1);
    chk("s3_addr", mem_addr, 32'h10);
    wait_valid(20, "s3_valid");
`endif
    chk("s3_pc", out_pc, 32'h14);
    chk("s3_instr", out_instr, w(32'h14));

    // Asynchronous reset during WAIT, then a late response that must be ignored.
    do_reset();
    mem_auto = 1'b1;
    for (int c = 0; c < 40 && !(out_valid && mem_req); c++) step();
    chk("s4_setup", {31'h0, (out_valid && mem_req)}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("s4_async_req", {31'h0, mem_req}, 32'h0);
    chk("s4_async_valid", {31'h0, out_valid}, 32'h0);
    chk("s4_async_addr", mem_addr, 32'h0);
    chk("s4_async_pc", out_pc, 32'h0);
    chk("s4_async_instr", out_instr, 32'h0);
    mem_auto = 1'b0;
    pend     = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = {4{32'hDEAD_BEEF}};
    step();
    chk("s4_restart_req", {31'h0, mem_req}, 32'h1);
    chk("s4_restart_addr", mem_addr, 32'h0);
    mem_auto = 1'b1;
    wait_valid(20, "s4_valid");
    chk("s4_pc", out_pc, 32'h0);
    chk("s4_instr", out_instr, w(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
